// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshake, status flags and an iterative
// shift-add multiplier; one operation in flight at a time.
module alu_seq_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept_c;
    logic             load_c;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [SW-1:0]    cnt;
    logic [SW-1:0]    shamt_c;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, mul_sum;
    logic [WIDTH-1:0] nxt_lo, nxt_hi;
    logic             nxt_c, nxt_v;

    assign accept_c = in_valid & in_ready;
    assign shamt_c  = b[SW-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; load_c marks the edge that enters DONE
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        case (state)
            IDLE: if (accept_c) begin
                state_nxt = (op == OP_MUL) ? BUSY : DONE;
                load_c    = (op != OP_MUL);
            end
            BUSY: if (cnt == SW'(WIDTH - 1)) begin
                state_nxt = DONE;
                load_c    = 1'b1;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result selection: final multiplier step while BUSY, else the live operands
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        shl_w   = {1'b0, a} << shamt_c;
        shr_w   = {a, 1'b0} >> shamt_c;
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        nxt_lo  = '0;
        nxt_hi  = '0;
        nxt_c   = 1'b0;
        nxt_v   = 1'b0;
        if (state == BUSY) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
            nxt_c  = |mul_sum[WIDTH:1];
        end else begin
            case (op)
                OP_ADD: begin
                    nxt_lo = add_w[WIDTH-1:0];
                    nxt_c  = add_w[WIDTH];
                    nxt_v  = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
                end
                OP_SUB: begin
                    nxt_lo = sub_w[WIDTH-1:0];
                    nxt_c  = sub_w[WIDTH];
                    nxt_v  = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
                end
                OP_AND: nxt_lo = a & b;
                OP_OR:  nxt_lo = a | b;
                OP_XOR: nxt_lo = a ^ b;
                OP_SHL: begin
                    nxt_lo = shl_w[WIDTH-1:0];
                    nxt_c  = shl_w[WIDTH];
                end
                OP_SHR: begin
                    nxt_lo = shr_w[WIDTH:1];
                    nxt_c  = shr_w[0];
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs, multiplier datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (state == IDLE && accept_c && op == OP_MUL) begin
                mcand  <= a;
                acc_lo <= b;
                acc_hi <= '0;
                cnt    <= '0;
            end else if (state == BUSY) begin
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                cnt              <= cnt + SW'(1);
            end
            if (load_c) begin
                res_lo <= nxt_lo;
                res_hi <= nxt_hi;
                flag_c <= nxt_c;
                flag_z <= (nxt_lo == '0);
                flag_n <= nxt_lo[MSB];
                flag_v <= nxt_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8): directed scenarios plus
// randomized operations against an arithmetic reference model.
module tb_alu_seq_core;

    localparam int unsigned W   = 8;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b, res_lo, res_hi;
    logic         flag_c, flag_z, flag_n, flag_v;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    // Reference model from the opcode definitions, using plain integer arithmetic
    function automatic void model(input int unsigned o, input int unsigned x, input int unsigned y,
                                  output int unsigned lo, output int unsigned hi,
                                  output bit c, output bit v);
        int unsigned s;
        int sx, sy, sr;
        s  = y % W;
        sx = (x >= MOD / 2) ? int'(x) - int'(MOD) : int'(x);
        sy = (y >= MOD / 2) ? int'(y) - int'(MOD) : int'(y);
        lo = 0; hi = 0; c = 0; v = 0;
        case (o)
            0: begin lo = (x + y) % MOD; c = (x + y) >= MOD; sr = sx + sy;
                     v = (sr > int'(MOD / 2) - 1) || (sr < -int'(MOD / 2)); end
            1: begin lo = (x + MOD - y) % MOD; c = (x < y); sr = sx - sy;
                     v = (sr > int'(MOD / 2) - 1) || (sr < -int'(MOD / 2)); end
            2: lo = x & y;
            3: lo = x | y;
            4: lo = x ^ y;
            5: begin lo = (x << s) % MOD; c = (s != 0) && (((x >> (W - s)) & 1) == 1); end
            6: begin lo = x >> s; c = (s != 0) && (((x >> (s - 1)) & 1) == 1); end
            default: begin lo = (x * y) % MOD; hi = (x * y) / MOD; c = (hi != 0); end
        endcase
    endfunction

    // Issue one bundle and wait (bounded) for out_valid; lat counts edges incl. the accept edge
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; busy = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (!in_ready) busy++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b lo=%h hi=%h cznv=%b%b%b%b, expected 1 0 00 00 0000",
                     in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, flag_n, flag_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        int lat, busy;
        run_op(3'd0, 8'h7F, 8'h01, lat, busy);
        n_tests++;
        if ({lat, res_lo, flag_c, flag_v, flag_n, flag_z} !== {32'd1, 8'h80, 4'b0110}) begin
            n_fail++;
            $display("FAIL add_ovf: lat=%0d lo=%h c=%b v=%b n=%b z=%b, expected lat=1 lo=80 c=0 v=1 n=1 z=0",
                     lat, res_lo, flag_c, flag_v, flag_n, flag_z);
        end
        take();
        run_op(3'd1, 8'h03, 8'h05, lat, busy);
        n_tests++;
        if ({res_lo, flag_c, flag_v, flag_n} !== {8'hFE, 3'b101}) begin
            n_fail++;
            $display("FAIL sub_borrow: lo=%h c=%b v=%b n=%b, expected lo=fe c=1 v=0 n=1",
                     res_lo, flag_c, flag_v, flag_n);
        end
        take();
        run_op(3'd0, 8'hFF, 8'h01, lat, busy);
        n_tests++;
        if ({res_lo, flag_c, flag_z} !== {8'h00, 2'b11}) begin
            n_fail++;
            $display("FAIL add_carry_zero: lo=%h c=%b z=%b, expected lo=00 c=1 z=1", res_lo, flag_c, flag_z);
        end
        take();
    endtask

    task automatic test_mul();
        int lat, busy;
        run_op(3'd7, 8'hFF, 8'hFF, lat, busy);
        n_tests++;
        if (busy !== 8 || lat !== 9) begin
            n_fail++;
            $display("FAIL mul_timing: busy=%0d lat=%0d, expected busy=8 lat=9", busy, lat);
        end
        n_tests++;
        if ({res_hi, res_lo, flag_c, flag_z, flag_n, flag_v} !== {16'hFE01, 4'b1000}) begin
            n_fail++;
            $display("FAIL mul_result: hi=%h lo=%h c=%b z=%b n=%b v=%b, expected hi=fe lo=01 c=1 z=0 n=0 v=0",
                     res_hi, res_lo, flag_c, flag_z, flag_n, flag_v);
        end
        take();
    endtask

    task automatic test_backpressure();
        int lat, busy;
        run_op(3'd5, 8'h81, 8'h01, lat, busy);
        in_valid = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({out_valid, in_ready, res_lo, flag_c, res_hi} !== {2'b10, 8'h02, 1'b1, 8'h00}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b lo=%h c=%b hi=%h, expected 1 0 02 1 00",
                         i, out_valid, in_ready, res_lo, flag_c, res_hi);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        take();
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat, busy, stray;
        @(negedge clk);
        op = 3'd7; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_mul: in_ready=%b out_valid=%b lo=%h hi=%h cznv=%b%b%b%b, expected 1 0 00 00 0000",
                     in_ready, out_valid, res_lo, res_hi, flag_c, flag_z, flag_n, flag_v);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL aborted_mul_result: out_valid seen %0d cycles, expected 0", stray);
        end
        run_op(3'd0, 8'h02, 8'h03, lat, busy);
        n_tests++;
        if ({lat, res_lo, res_hi} !== {32'd1, 8'h05, 8'h00}) begin
            n_fail++;
            $display("FAIL add_after_reset: lat=%0d lo=%h hi=%h, expected lat=1 lo=05 hi=00", lat, res_lo, res_hi);
        end
        take();
    endtask

    task automatic test_shift();
        int lat, busy;
        run_op(3'd6, 8'h80, 8'h0F, lat, busy);
        n_tests++;
        if ({res_lo, flag_c} !== {8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL shr_by7: lo=%h c=%b, expected lo=01 c=0", res_lo, flag_c);
        end
        take();
        run_op(3'd6, 8'h80, 8'h08, lat, busy);
        n_tests++;
        if ({res_lo, flag_c, flag_n} !== {8'h80, 2'b01}) begin
            n_fail++;
            $display("FAIL shr_by0: lo=%h c=%b n=%b, expected lo=80 c=0 n=1", res_lo, flag_c, flag_n);
        end
        take();
    endtask

    task automatic test_random();
        int lat, busy;
        int unsigned elo, ehi;
        bit ec, ev;
        logic [2:0]   o;
        logic [W-1:0] x, y;
        logic [2*W+3:0] got, exp;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            model(int'(o), int'(x), int'(y), elo, ehi, ec, ev);
            run_op(o, x, y, lat, busy);
            n_tests++;
            if (lat !== ((o == 3'd7) ? 9 : 1)) begin
                n_fail++;
                $display("FAIL rand_latency[%0d] op=%0d: lat=%0d, expected %0d", i, o, lat, (o == 3'd7) ? 9 : 1);
            end
            got = {res_lo, res_hi, flag_c, flag_z, flag_n, flag_v};
            exp = {W'(elo), W'(ehi), ec, (elo == 0), (elo >= MOD / 2), ev};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: lo/hi/cznv=%h, expected %h", i, o, x, y, got, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            n_tests++;
            if (got !== {res_lo, res_hi, flag_c, flag_z, flag_n, flag_v} || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_stable[%0d]: out_valid=%b result changed while waiting", i, out_valid);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
